dbus_timer_gpio: RTL and testbench

DBUS_TIMER_GPIO -- requirements
Module: dbus_timer_gpio

---
 rtl/dbus_timer_gpio_pkg.sv | 43 ++++
 rtl/dbus_timer_gpio_if.sv | 23 ++
 rtl/dbus_timer_gpio_load_extend.sv | 27 ++
 rtl/dbus_timer_gpio.sv | 149 ++++++++++++++
 tb/tb_dbus_timer_gpio.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_timer_gpio_pkg.sv
// Shared data-bus encodings, register offsets and reset constants
// for the timer/GPIO peripheral and its bus neighbours.
package dbus_timer_gpio_pkg;

   localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
   localparam logic [5:0] OFF_GPIO_IN  = 6'h04;
   localparam logic [5:0] OFF_MTIME_LO = 6'h08;
   localparam logic [5:0] OFF_MTIME_HI = 6'h0C;
   localparam logic [5:0] OFF_CMP_LO   = 6'h10;
   localparam logic [5:0] OFF_CMP_HI   = 6'h14;
   localparam logic [5:0] OFF_SCRATCH  = 6'h18;

   typedef enum logic [1:0] {
      ST_SB   = 2'b00,
      ST_SH   = 2'b01,
      ST_SW   = 2'b10,
      ST_NONE = 2'b11
   } store_type_e;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } load_type_e;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [31:0] merge_be(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dbus_timer_gpio_if.sv
// Core-side data-memory bus: strobes, address, data and select.
interface dbus_timer_gpio_if;
   logic        data_mem_write;
   logic        data_mem_read;
   logic [31:0] data_mem_addr;
   logic [1:0]  store_type;
   logic [2:0]  load_type;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        sel_hit;

   modport master (
      output data_mem_write, data_mem_read, data_mem_addr,
      output store_type, load_type, write_data,
      input  read_data, sel_hit
   );

   modport slave (
      input  data_mem_write, data_mem_read, data_mem_addr,
      input  store_type, load_type, write_data,
      output read_data, sel_hit
   );
endinterface

// File: rtl/dbus_timer_gpio_load_extend.sv
// Byte/half/word extraction with sign or zero extension for loads.
module load_extend
   import dbus_timer_gpio_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_type,
   output logic [31:0] o_data
);

   logic [15:0] w_sh;

   assign w_sh = 16'(i_word >> {i_off, 3'b000});

   always_comb begin
      o_data = '0;
      case (i_type)
         LD_LB:   o_data = {{24{w_sh[7]}}, w_sh[7:0]};
         LD_LH:   o_data = {{16{w_sh[15]}}, w_sh};
         LD_LW:   o_data = (i_off == 2'b00) ? i_word : '0;
         LD_LBU:  o_data = {24'h0, w_sh[7:0]};
         LD_LHU:  o_data = {16'h0, w_sh};
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/dbus_timer_gpio.sv
// Memory-mapped GPIO, scratch register and 64-bit machine timer
// with compare interrupt, sitting beside Data_Memory on the data bus.
module dbus_timer_gpio
   import dbus_timer_gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   dbus_timer_gpio_if.slave   bus,
   input  logic [7:0]         gpio_in,
   output logic [7:0]         gpio_out,
   output logic               timer_irq
);

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic        w_in_win;
   logic        w_rd;
   logic        w_wr;
   logic [5:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wlane;
   logic [31:0] w_rword;
   logic [31:0] w_rdata;
   logic [63:0] w_mtime_nxt;
   logic [63:0] w_cmp_nxt;
   logic [15:0] w_presc_nxt;

   logic [7:0]  r_gpio_out;
   logic [7:0]  r_sync1;
   logic [7:0]  r_sync2;
   logic [31:0] r_scratch;
   logic [31:0] r_shadow;
   logic [63:0] r_mtime;
   logic [63:0] r_cmp;
   logic [15:0] r_presc;
   logic        r_irq;

   assign w_in_win = (bus.data_mem_addr[31:6] == BASE_ADDR[31:6]);
   assign w_off    = {bus.data_mem_addr[5:2], 2'b00};
   assign w_rd     = bus.data_mem_read & w_in_win;
   assign w_wr     = bus.data_mem_write & w_in_win;

   assign bus.sel_hit = w_in_win
                      & (bus.data_mem_read | bus.data_mem_write);

   // Lane enables are zero for misaligned or invalid stores
   always_comb begin
      w_be    = '0;
      w_wlane = bus.write_data;
      case (bus.store_type)
         ST_SB: begin
            w_be    = 4'b0001 << bus.data_mem_addr[1:0];
            w_wlane = {4{bus.write_data[7:0]}};
         end
         ST_SH: begin
            if (!bus.data_mem_addr[0])
               w_be = bus.data_mem_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{bus.write_data[15:0]}};
         end
         ST_SW: begin
            if (bus.data_mem_addr[1:0] == 2'b00) w_be = 4'b1111;
         end
         default: w_be = '0;
      endcase
      if (!w_wr) w_be = '0;
   end

   always_comb begin
      w_rword = '0;
      case (w_off)
         OFF_GPIO_OUT: w_rword = {24'h0, r_gpio_out};
         OFF_GPIO_IN:  w_rword = {24'h0, r_sync2};
         OFF_MTIME_LO: w_rword = r_mtime[31:0];
         OFF_MTIME_HI: w_rword = r_shadow;
         OFF_CMP_LO:   w_rword = r_cmp[31:0];
         OFF_CMP_HI:   w_rword = r_cmp[63:32];
         OFF_SCRATCH:  w_rword = r_scratch;
         default:      w_rword = '0;
      endcase
   end

   load_extend u_load_extend (
      .i_word (w_rword),
      .i_off  (bus.data_mem_addr[1:0]),
      .i_type (bus.load_type),
      .o_data (w_rdata)
   );

   assign bus.read_data = w_rd ? w_rdata : '0;

   // A store to mtime beats the tick and restarts the prescaler
   always_comb begin
      w_mtime_nxt = r_mtime;
      w_cmp_nxt   = r_cmp;
      w_presc_nxt = r_presc + 16'd1;
      if (r_presc == PS_LAST) begin
         w_presc_nxt = '0;
         w_mtime_nxt = r_mtime + 64'd1;
      end
      if (w_off == OFF_MTIME_LO && |w_be) begin
         w_mtime_nxt = {r_mtime[63:32],
                        merge_be(r_mtime[31:0], w_wlane, w_be)};
         w_presc_nxt = '0;
      end
      if (w_off == OFF_MTIME_HI && |w_be) begin
         w_mtime_nxt = {merge_be(r_mtime[63:32], w_wlane, w_be),
                        r_mtime[31:0]};
         w_presc_nxt = '0;
      end
      if (w_off == OFF_CMP_LO)
         w_cmp_nxt[31:0] = merge_be(r_cmp[31:0], w_wlane, w_be);
      if (w_off == OFF_CMP_HI)
         w_cmp_nxt[63:32] = merge_be(r_cmp[63:32], w_wlane, w_be);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gpio_out <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_scratch  <= '0;
         r_shadow   <= '0;
         r_mtime    <= '0;
         r_cmp      <= MTIMECMP_RST;
         r_presc    <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
         r_mtime <= w_mtime_nxt;
         r_cmp   <= w_cmp_nxt;
         r_presc <= w_presc_nxt;
         r_irq   <= (w_mtime_nxt >= w_cmp_nxt);
         if (w_off == OFF_GPIO_OUT && w_be[0])
            r_gpio_out <= w_wlane[7:0];
         if (w_off == OFF_SCRATCH)
            r_scratch <= merge_be(r_scratch, w_wlane, w_be);
         if (w_rd && w_off == OFF_MTIME_LO)
            r_shadow <= r_mtime[63:32];
      end
   end

   assign gpio_out  = r_gpio_out;
   assign timer_irq = r_irq;

endmodule

// File: tb/tb_dbus_timer_gpio.sv
// Scoreboard bench for dbus_timer_gpio: directed register scenarios
// followed by random bus traffic against a time-based reference model.
module tb_dbus_timer_gpio;
   import dbus_timer_gpio_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int PS = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] gpio_in = 8'h00;
   logic [7:0] gpio_out;
   logic       timer_irq;

   dbus_timer_gpio_if bus ();

   dbus_timer_gpio #(
      .BASE_ADDR (BASE),
      .PRESCALE  (PS)
   ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   longint unsigned cyc;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Reference state: mtime is derived from elapsed clock edges
   logic [7:0]      m_gpio_out;
   logic [7:0]      m_gpio_in = 8'h00;
   logic [31:0]     m_scratch;
   logic [31:0]     m_shadow;
   logic [63:0]     m_cmp;
   logic [63:0]     m_mbase;
   longint unsigned m_nbase;

   bit              p_vld;
   logic [31:0]     p_addr;
   logic [31:0]     p_wd;
   logic [1:0]      p_st;
   longint unsigned p_n;

   bit chk_pins = 1'b0;

   typedef struct {
      logic        sel;
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] m_mtime(input longint unsigned n);
      return m_mbase + 64'((n - m_nbase) / PS);
   endfunction

   task automatic m_reset();
      m_gpio_out = '0;
      m_scratch  = '0;
      m_shadow   = '0;
      m_cmp      = '1;
      m_mbase    = '0;
      m_nbase    = 0;
      p_vld      = 1'b0;
   endtask

   function automatic logic [31:0] m_word(input logic [31:0] a,
                                          input longint unsigned n);
      logic [63:0] t;
      t = m_mtime(n);
      case (a[5:2])
         4'd0: return {24'h0, m_gpio_out};
         4'd1: return {24'h0, m_gpio_in};
         4'd2: return t[31:0];
         4'd3: return m_shadow;
         4'd4: return m_cmp[31:0];
         4'd5: return m_cmp[63:32];
         4'd6: return m_scratch;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ld_ext(input logic [31:0] w,
                                          input logic [1:0] off,
                                          input logic [2:0] lt);
      logic [31:0] s;
      int v;
      s = w >> (8 * int'(off));
      case (lt)
         3'b000: begin
            v = int'(s[7:0]);
            if (v > 127) v = v - 256;
            return 32'(v);
         end
         3'b001: begin
            v = int'(s[15:0]);
            if (v > 32767) v = v - 65536;
            return 32'(v);
         end
         3'b010: return (off == 2'b00) ? w : 32'h0;
         3'b100: return {24'h0, s[7:0]};
         3'b101: return {16'h0, s[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] st_apply(input logic [31:0] old,
                                            input logic [1:0] a,
                                            input logic [1:0] st,
                                            input logic [31:0] wd,
                                            output bit chg);
      logic [31:0] r;
      int k;
      r = old;
      chg = 1'b0;
      case (st)
         2'b00: begin
            k = int'(a);
            r[8*k +: 8] = wd[7:0];
            chg = 1'b1;
         end
         2'b01: if (!a[0]) begin
            k = int'(a[1]);
            r[16*k +: 16] = wd[15:0];
            chg = 1'b1;
         end
         2'b10: if (a == 2'b00) begin
            r = wd;
            chg = 1'b1;
         end
         default: chg = 1'b0;
      endcase
      return r;
   endfunction

   task automatic apply_pending();
      logic [63:0] cur;
      logic [31:0] w;
      bit c;
      if (!p_vld) return;
      p_vld = 1'b0;
      cur = m_mtime(p_n);
      case (p_addr[5:2])
         4'd0: begin
            w = st_apply({24'h0, m_gpio_out}, p_addr[1:0], p_st, p_wd, c);
            m_gpio_out = w[7:0];
         end
         4'd2: begin
            w = st_apply(cur[31:0], p_addr[1:0], p_st, p_wd, c);
            if (c) begin
               m_mbase = {cur[63:32], w};
               m_nbase = p_n + 1;
            end
         end
         4'd3: begin
            w = st_apply(cur[63:32], p_addr[1:0], p_st, p_wd, c);
            if (c) begin
               m_mbase = {w, cur[31:0]};
               m_nbase = p_n + 1;
            end
         end
         4'd4: m_cmp[31:0] = st_apply(m_cmp[31:0], p_addr[1:0], p_st, p_wd, c);
         4'd5: m_cmp[63:32] = st_apply(m_cmp[63:32], p_addr[1:0], p_st, p_wd, c);
         4'd6: m_scratch = st_apply(m_scratch, p_addr[1:0], p_st, p_wd, c);
         default: c = 1'b0;
      endcase
   endtask

   task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [1:0] st, input logic [2:0] lt,
                       input logic [31:0] wd, input bit use_exp,
                       input logic [31:0] exp_d);
      exp_t e;
      bit in_win;
      logic [63:0] t;
      @(posedge clk);
      apply_pending();
      #1;
      bus.data_mem_read  = rd;
      bus.data_mem_write = wr;
      bus.data_mem_addr  = addr;
      bus.store_type     = st;
      bus.load_type      = lt;
      bus.write_data     = wd;
      in_win = (addr[31:6] == BASE[31:6]);
      if (rd || wr) begin
         e.sel  = in_win;
         e.addr = addr;
         if (use_exp) e.data = exp_d;
         else if (rd && in_win) e.data = ld_ext(m_word(addr, cyc), addr[1:0], lt);
         else e.data = 32'h0;
         q.push_back(e);
      end
      if (rd && in_win && addr[5:2] == 4'd2) begin
         t = m_mtime(cyc);
         m_shadow = t[63:32];
      end
      if (wr && in_win) begin
         p_vld  = 1'b1;
         p_addr = addr;
         p_st   = st;
         p_wd   = wd;
         p_n    = cyc;
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         apply_pending();
         #1;
         bus.data_mem_read  = 1'b0;
         bus.data_mem_write = 1'b0;
      end
   endtask

   task automatic wr(input logic [5:0] off, input logic [1:0] st,
                     input logic [31:0] wd);
      xact(1'b0, 1'b1, BASE + {26'h0, off}, st, 3'b000, wd, 1'b0, 32'h0);
   endtask

   task automatic rd_exp(input logic [5:0] off, input logic [2:0] lt,
                         input logic [31:0] exp_d);
      xact(1'b1, 1'b0, BASE + {26'h0, off}, 2'b00, lt, 32'h0, 1'b1, exp_d);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.data_mem_read || bus.data_mem_write) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty addr=%h", bus.data_mem_addr);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sel_hit", {63'h0, bus.sel_hit}, {63'h0, e.sel});
               chk("read_data", {32'h0, bus.read_data}, {32'h0, e.data});
            end
         end
         if (chk_pins) begin
            chk("gpio_out", {56'h0, gpio_out}, {56'h0, m_gpio_out});
            chk("timer_irq", {63'h0, timer_irq},
                {63'h0, (m_mtime(cyc) >= m_cmp)});
         end
      end
   end

   initial begin
      bit seen;
      bus.data_mem_read  = 1'b0;
      bus.data_mem_write = 1'b0;
      bus.data_mem_addr  = 32'h0;
      bus.store_type     = 2'b00;
      bus.load_type      = 3'b000;
      bus.write_data     = 32'h0;
      m_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio_out", {56'h0, gpio_out}, 64'h0);
      chk("rst_irq", {63'h0, timer_irq}, 64'h0);
      reset_n = 1'b1;

      rd_exp(6'h00, LD_LW, 32'h0);
      rd_exp(6'h18, LD_LW, 32'h0);
      rd_exp(6'h10, LD_LW, 32'hFFFF_FFFF);
      rd_exp(6'h14, LD_LW, 32'hFFFF_FFFF);
      rd_exp(6'h04, LD_LW, 32'h0);
      idle(1);

      // mtime after 40 edges with prescale 4
      while (cyc < 39) begin
         @(posedge clk);
         #1;
      end
      rd_exp(6'h08, LD_LW, 32'd10);
      rd_exp(6'h0C, LD_LW, 32'd0);
      wr(6'h08, ST_SW, 32'hFFFF_FFFF);
      wr(6'h0C, ST_SW, 32'h0);
      idle(4);
      rd_exp(6'h08, LD_LW, 32'h0);
      rd_exp(6'h0C, LD_LW, 32'h1);

      wr(6'h18, ST_SW, 32'h1234_5678);
      rd_exp(6'h18, LD_LW, 32'h1234_5678);
      rd_exp(6'h1B, LD_LB, 32'h0000_0012);
      rd_exp(6'h18, LD_LBU, 32'h0000_0078);
      rd_exp(6'h1A, LD_LH, 32'h0000_1234);
      rd_exp(6'h19, LD_LW, 32'h0);
      rd_exp(6'h18, 3'b111, 32'h0);

      wr(6'h1A, ST_SW, 32'hFFFF_FFFF);
      wr(6'h18, ST_NONE, 32'hFFFF_FFFF);
      wr(6'h19, ST_SH, 32'hFFFF_FFFF);
      rd_exp(6'h18, LD_LW, 32'h1234_5678);

      wr(6'h00, ST_SB, 32'h0000_00A5);
      wr(6'h01, ST_SH, 32'h0000_5A5A);
      @(negedge clk);
      chk("gpio_sb", {56'h0, gpio_out}, 64'hA5);
      idle(1);
      @(negedge clk);
      chk("gpio_sh_misaligned", {56'h0, gpio_out}, 64'hA5);
      rd_exp(6'h00, LD_LB, 32'hFFFF_FFA5);
      rd_exp(6'h00, LD_LH, 32'h0000_00A5);
      rd_exp(6'h00, LD_LBU, 32'h0000_00A5);

      xact(1'b1, 1'b1, BASE + 32'h18, ST_SW, LD_LW, 32'hCAFE_F00D,
           1'b1, 32'h1234_5678);
      rd_exp(6'h18, LD_LW, 32'hCAFE_F00D);

      idle(1);
      gpio_in = 8'h3C;
      rd_exp(6'h04, LD_LW, 32'h0);
      rd_exp(6'h04, LD_LW, 32'h0000_003C);
      rd_exp(6'h05, LD_LBU, 32'h0);
      m_gpio_in = 8'h3C;

      xact(1'b1, 1'b0, BASE + 32'h40, 2'b00, LD_LW, 32'h0, 1'b1, 32'h0);
      xact(1'b1, 1'b0, BASE - 32'h4, 2'b00, LD_LW, 32'h0, 1'b1, 32'h0);
      xact(1'b0, 1'b1, BASE + 32'h58, ST_SW, LD_LW, 32'hBAD0_BAD0,
           1'b0, 32'h0);
      rd_exp(6'h18, LD_LW, 32'hCAFE_F00D);

      // Timer compare at 20, then raise the compare above mtime
      wr(6'h0C, ST_SW, 32'h0);
      wr(6'h08, ST_SW, 32'h0);
      wr(6'h14, ST_SW, 32'h0);
      wr(6'h10, ST_SW, 32'd20);
      idle(1);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         chk("irq_track", {63'h0, timer_irq},
             {63'h0, (m_mtime(cyc) >= m_cmp)});
         if (timer_irq) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL irq_rise_timeout actual=0 required=1");
      end
      rd_exp(6'h08, LD_LW, 32'd20);
      wr(6'h10, ST_SW, 32'd100);
      @(negedge clk);
      chk("irq_before_cmp_edge", {63'h0, timer_irq}, 64'h1);
      idle(1);
      @(negedge clk);
      chk("irq_after_cmp_edge", {63'h0, timer_irq}, 64'h0);

      wr(6'h18, ST_SW, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      chk("midrst_gpio_out", {56'h0, gpio_out}, 64'h0);
      chk("midrst_irq", {63'h0, timer_irq}, 64'h0);
      bus.data_mem_read  = 1'b0;
      bus.data_mem_write = 1'b0;
      reset_n = 1'b1;
      rd_exp(6'h18, LD_LW, 32'h0);
      rd_exp(6'h10, LD_LW, 32'hFFFF_FFFF);
      rd_exp(6'h00, LD_LW, 32'h0);

      idle(1);
      chk_pins = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [5:0]  off;
         logic [31:0] addr;
         bit          r;
         bit          w;
         if ($urandom_range(0, 9) == 0) begin
            idle(1);
         end else begin
            off  = 6'($urandom_range(0, 31));
            addr = BASE + {26'h0, off};
            if ($urandom_range(0, 9) == 0) addr = addr + 32'h40;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            xact(r, w, addr, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), $urandom, 1'b0, 32'h0);
         end
      end
      idle(2);
      chk_pins = 1'b0;

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
